// File: rtl/sd_cmd_pkg.sv
// Shared constants and the controller state type for the SD command transmit path.
package sd_cmd_pkg;

    localparam int         FRAME_W   = 48;
    // x^7 + x^3 + 1, with the x^7 term implied by the shift-out
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;
    localparam logic END_BIT   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC,
        ST_LOAD,
        ST_SEND,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 generator, MSB first, zero initial value.
// Only compiled when CMD_CRC7_EN is defined; without it the CRC field comes from crc_in.
`ifdef CMD_CRC7_EN
module sd_crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic       sd_clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       data_in,
    output logic [6:0] crc_out
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       feedback;

    // Next CRC value: clear has priority over shifting a new bit in
    always_comb begin
        crc_d    = crc_q;
        feedback = data_in ^ crc_q[6];
        if (clear) begin
            crc_d = '0;
        end else if (shift_en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

    // CRC register
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule
`endif

// File: rtl/sd_cmd_tx_controller.sv
// SD command transmit controller: accepts a command, builds the 48-bit frame,
// loads it into the serializer and supervises the send with a cycle timeout.
// Build option CMD_CRC7_EN: compute CRC7 internally (adds the CRC state);
// otherwise the CRC7 field is taken from crc_in at acceptance.
//
// state | meaning
// IDLE  | ready for a command
// CRC   | shifting frame bits 47..8 through CRC7, one per cycle
// LOAD  | one-cycle serializer load strobe
// SEND  | serializer running, timeout counter active
// DONE  | one-cycle success pulse
// ERR   | one-cycle timeout pulse
module sd_cmd_tx_controller #(
    parameter int FRAME_W     = sd_cmd_pkg::FRAME_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_argument,
    input  logic [6:0]         crc_in,
    output logic [FRAME_W-1:0] ser_parallel,
    output logic               ser_enable,
    output logic               ser_load_send,
    input  logic               ser_complete,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    import sd_cmd_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               accept;

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_ready && cmd_valid;

`ifdef CMD_CRC7_EN
    localparam int IDX_W = $clog2(FRAME_W);

    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [6:0]       crc_val;
    logic             crc_last;
    logic             unused_crc_in;

    assign unused_crc_in = ^crc_in;
    assign crc_last      = (bit_idx_q == IDX_W'(8));

    // Bit pointer walks down from the start bit to bit 8 during CRC
    always_comb begin
        bit_idx_d = bit_idx_q;
        if (accept) begin
            bit_idx_d = IDX_W'(FRAME_W - 1);
        end else if ((state_q == ST_CRC) && !crc_last) begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
        end
    end

    // Bit pointer register
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            bit_idx_q <= '0;
        end else begin
            bit_idx_q <= bit_idx_d;
        end
    end

    sd_crc7_serial u_crc7 (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (accept),
        .shift_en (state_q == ST_CRC),
        .data_in  (frame_q[bit_idx_q]),
        .crc_out  (crc_val)
    );

    // CRC register is cleared only on acceptance, so the field stays stable afterwards
    assign ser_parallel = frame_q | {{(FRAME_W-8){1'b0}}, crc_val, 1'b0};
`else
    assign ser_parallel = frame_q;
`endif

    // Frame capture on acceptance, held otherwise
    always_comb begin
        frame_d = frame_q;
        if (accept) begin
            frame_d                   = '0;
            frame_d[FRAME_W-1]        = START_BIT;
            frame_d[FRAME_W-2]        = TX_BIT;
            frame_d[FRAME_W-3 -: 6]   = cmd_index;
            frame_d[FRAME_W-9 -: 32]  = cmd_argument;
`ifndef CMD_CRC7_EN
            frame_d[7:1]              = crc_in;
`endif
            frame_d[0]                = END_BIT;
        end
    end

    // Next-state and timeout counter; complete beats timeout in the same cycle
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef CMD_CRC7_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_LOAD;
`endif
                end
            end
            ST_CRC: begin
`ifdef CMD_CRC7_EN
                if (crc_last) begin
                    state_d = ST_LOAD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (ser_complete) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, frame and timeout registers
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign ser_enable    = (state_q == ST_LOAD);
    assign ser_load_send = (state_q == ST_SEND);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign timeout_err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_sd_cmd_tx_controller.sv
// Scoreboard bench for sd_cmd_tx_controller: the driver queues expected
// load/done/timeout events, a monitor pops and compares them as they appear.
module tb_sd_cmd_tx_controller;

`ifdef CMD_CRC7_EN
    localparam int LAT = 41;
`else
    localparam int LAT = 1;
`endif

    localparam logic [47:0] F_CMD0  = 48'h400000000095;
    localparam logic [47:0] F_CMD8  = 48'h48000001AA87;
    localparam logic [47:0] F_CMD17 = 48'h510000000055;
`ifdef CMD_CRC7_EN
    localparam logic [47:0] F_CMD0_BADCRC = 48'h400000000095;
`else
    localparam logic [47:0] F_CMD0_BADCRC = 48'h4000000000FF;
`endif

    logic        sd_clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_argument = '0;
    logic [6:0]  crc_in = '0;
    logic [47:0] ser_parallel;
    logic        ser_enable;
    logic        ser_load_send;
    logic        ser_complete = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout_err;

    sd_cmd_tx_controller #(.FRAME_W(48), .TIMEOUT_CYC(64)) dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_index     (cmd_index),
        .cmd_argument  (cmd_argument),
        .crc_in        (crc_in),
        .ser_parallel  (ser_parallel),
        .ser_enable    (ser_enable),
        .ser_load_send (ser_load_send),
        .ser_complete  (ser_complete),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    always #5 sd_clock = ~sd_clock;

    int cyc = 0;
    always @(posedge sd_clock) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 load, 1 done, 2 timeout
        logic [47:0] frame;
        int          lat;    // cycles after the accepting cycle
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_acc    = 0;
    int  exp_acc  = 0;
    int  last_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ser_parallel"}, ser_parallel, 0);
        chk({tag, "_ser_enable"}, ser_enable, 0);
        chk({tag, "_ser_load_send"}, ser_load_send, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    // Monitor: pops one expected event for every load/done/timeout seen
    always begin
        ev_t e;
        int  k_now;
        @(negedge sd_clock);
        #2;
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                last_acc = cyc;
                n_acc++;
            end
            if (ser_enable || done || timeout_err) begin
                k_now = ser_enable ? 0 : (done ? 1 : 2);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_event: got kind %0d, expected none (t=%0t)", k_now, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", k_now, e.kind);
                    chk("event_latency", cyc - last_acc, e.lat);
                    chk("event_frame", ser_parallel, e.frame);
                    if (ser_enable) chk("load_send_during_load", ser_load_send, 0);
                    else chk("busy_at_end_pulse", busy, 1);
                end
            end
        end
    end

    // Issue one command; k = SEND cycle carrying ser_complete (-1 none);
    // rst_at = cycle after accept at which reset is pulsed (-1 none)
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                           input logic [47:0] frame, input int k, input bit hold, input int rst_at);
        int  wait_n;
        int  evt_lat;
        int  last;
        ev_t e;
        @(negedge sd_clock);
        cmd_valid    = 1'b1;
        cmd_index    = idx;
        cmd_argument = arg;
        crc_in       = crc;
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge sd_clock);
            wait_n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL accept_wait: got cmd_ready 0 after %0d cycles, expected 1", wait_n);
            cmd_valid = 1'b0;
            return;
        end
        exp_acc++;
        e.kind = 0; e.frame = frame; e.lat = LAT;
        exp_q.push_back(e);
        if (k >= 0) begin
            evt_lat = LAT + 2 + k;
            e.kind  = 1;
        end else begin
            evt_lat = LAT + 65;
            e.kind  = 2;
        end
        e.lat = evt_lat;
        exp_q.push_back(e);
        last = (rst_at >= 0) ? rst_at : evt_lat + 1;
        for (int i = 1; i <= last; i++) begin
            @(negedge sd_clock);
            if (i == 1 && !hold) cmd_valid = 1'b0;
            if (hold && i == evt_lat) cmd_valid = 1'b0;
            ser_complete = (k >= 0 && i == LAT + 1 + k);
            if (i == LAT + 1) begin
                chk("send_load_send", ser_load_send, 1);
                chk("send_enable_low", ser_enable, 0);
            end
        end
        if (rst_at >= 0) begin
            reset        = 1'b1;
            ser_complete = 1'b0;
            cmd_valid    = 1'b0;
            exp_q.delete();
            #1;
            chk_quiet("midrun_reset");
            @(negedge sd_clock);
            reset = 1'b0;
            #1;
            chk("ready_after_reset", cmd_ready, 1);
        end else begin
            chk("ready_after_cmd", cmd_ready, 1);
            chk("idle_after_cmd", busy, 0);
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk_quiet("reset");
        repeat (2) @(negedge sd_clock);
        reset = 1'b0;
        #1;
        chk("ready_first", cmd_ready, 1);

        run_cmd(6'd0,  32'h0000_0000, 7'h4A, F_CMD0,  3,  1'b0, -1);
        run_cmd(6'd8,  32'h0000_01AA, 7'h43, F_CMD8,  0,  1'b0, -1);
        run_cmd(6'd17, 32'h0000_0000, 7'h2A, F_CMD17, 5,  1'b1, -1);
        run_cmd(6'd0,  32'h0000_0000, 7'h7F, F_CMD0_BADCRC, 2, 1'b0, -1);
        run_cmd(6'd0,  32'h0000_0000, 7'h4A, F_CMD0,  -1, 1'b0, -1);
        run_cmd(6'd8,  32'h0000_01AA, 7'h43, F_CMD8,  63, 1'b0, -1);
`ifdef CMD_CRC7_EN
        run_cmd(6'd17, 32'h0000_0000, 7'h2A, F_CMD17, -1, 1'b0, 20);
`endif
        run_cmd(6'd8,  32'h0000_01AA, 7'h43, F_CMD8,  -1, 1'b0, LAT + 11);
        run_cmd(6'd0,  32'h0000_0000, 7'h4A, F_CMD0,  1,  1'b0, -1);

        repeat (4) @(negedge sd_clock);
        chk("queue_drained", exp_q.size(), 0);
        chk("accept_count", n_acc, exp_acc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
